// File: rtl/not_gate_bist_if.sv
// Control/status bundle for not_gate_bist.
// master: the requester (drives start, observes status).
// slave : the BIST controller (observes start, drives status).
// Failure-log signals exist only when NOT_BIST_ERRLOG_EN is defined.
interface not_gate_bist_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
) ();
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
`ifdef NOT_BIST_ERRLOG_EN
    logic             fail_valid;
    logic [WIDTH-1:0] fail_vec;
    logic [WIDTH-1:0] fail_out;

    modport master (output start,
                    input  busy, done, pass, err_count, fail_valid, fail_vec, fail_out);
    modport slave  (input  start,
                    output busy, done, pass, err_count, fail_valid, fail_vec, fail_out);
`else
    modport master (output start,
                    input  busy, done, pass, err_count);
    modport slave  (input  start,
                    output busy, done, pass, err_count);
`endif
endinterface

// File: rtl/not_gate_bist.sv
// Self-test controller for a WIDTH-bit inverter bank.
// Steps a stimulus sequence onto dut_in, waits SETTLE cycles per vector,
// checks dut_out == ~dut_in and keeps a saturating count of failing vectors.
// MODE 0: exhaustive 0..2^WIDTH-1; MODE 1: walking-one then walking-zero.
// Optional first-failure log enabled by defining NOT_BIST_ERRLOG_EN.
module not_gate_bist #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned MODE   = 0,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    not_gate_bist_if.slave   ctl,
    input  logic [WIDTH-1:0] dut_out,
    output logic [WIDTH-1:0] dut_in
);

    localparam int unsigned NUM_VEC = (MODE == 0) ? (1 << WIDTH) : (2 * WIDTH);
    localparam int unsigned IDX_W   = WIDTH + 1;
    localparam int unsigned CNT_W   = $clog2(SETTLE + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dut_in_q, dut_in_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch;
`ifdef NOT_BIST_ERRLOG_EN
    logic             fail_valid_q, fail_valid_d;
    logic [WIDTH-1:0] fail_vec_q, fail_vec_d;
    logic [WIDTH-1:0] fail_out_q, fail_out_d;
`endif

    // Stimulus vector for sequence position idx.
    function automatic logic [WIDTH-1:0] vec_at(input logic [IDX_W-1:0] idx);
        if (MODE == 0)
            return idx[WIDTH-1:0];
        else if (idx < IDX_W'(WIDTH))
            return WIDTH'(1) << idx;
        else
            return ~(WIDTH'(1) << (idx - IDX_W'(WIDTH)));
    endfunction

    // Next-state logic: start acceptance, settle countdown, compare and advance.
    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
`ifdef NOT_BIST_ERRLOG_EN
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        fail_out_d   = fail_out_q;
`endif
        mismatch = (dut_out != ~dut_in_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (ctl.start) begin
                    state_d  = S_RUN;
                    dut_in_d = vec_at('0);
                    idx_d    = '0;
                    cnt_d    = SETTLE_V;
                    err_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
`ifdef NOT_BIST_ERRLOG_EN
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    fail_out_d   = '0;
`endif
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (mismatch) begin
                        if (err_q != '1)
                            err_d = err_q + ERR_W'(1);
`ifdef NOT_BIST_ERRLOG_EN
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_vec_d   = dut_in_q;
                            fail_out_d   = dut_out;
                        end
`endif
                    end
                    cnt_d = SETTLE_V;
                    if (idx_q == LAST_IDX) begin
                        // pass uses err_d so the last vector's verdict is included
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        dut_in_d = vec_at(idx_q + IDX_W'(1));
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            dut_in_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
`ifdef NOT_BIST_ERRLOG_EN
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            fail_out_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
`ifdef NOT_BIST_ERRLOG_EN
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            fail_out_q   <= fail_out_d;
`endif
        end
    end

    assign dut_in        = dut_in_q;
    assign ctl.busy      = busy_q;
    assign ctl.done      = done_q;
    assign ctl.pass      = pass_q;
    assign ctl.err_count = err_q;
`ifdef NOT_BIST_ERRLOG_EN
    assign ctl.fail_valid = fail_valid_q;
    assign ctl.fail_vec   = fail_vec_q;
    assign ctl.fail_out   = fail_out_q;
`endif

endmodule

// File: tb/tb_not_gate_bist.sv
// Bench for not_gate_bist: three instances (MODE 0, MODE 1, ERR_W=2),
// each with a faultable inverter-bank model on dut_out.
// Stimulus pushes expected run results; a monitor checks them at done.
module tb_not_gate_bist;

    localparam int unsigned SETTLE = 2;

    typedef struct packed {
        logic [15:0][3:0] vec;
        logic [7:0]       nv;
        logic [7:0]       err;
        logic             pass;
        logic             fv;
        logic [3:0]       fvec;
        logic [3:0]       fout;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [2:0] start_r;
    logic [2:0] fault [3];
    logic       end_req;

    logic [3:0] din_w  [3];
    logic [3:0] dout_w [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [7:0] err_w  [3];
`ifdef NOT_BIST_ERRLOG_EN
    logic       fv_w   [3];
    logic [3:0] fvec_w [3];
    logic [3:0] fout_w [3];
`endif

    exp_t exp_q [3][$];

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inverter bank model: 0 ideal, 1 bit2 stuck-0, 2 tied 0, 3 wrong at 9, 4 bit0 stuck-1
    function automatic logic [3:0] bank(input logic [3:0] d, input logic [2:0] f);
        case (f)
            3'd1:    return ~d & 4'b1011;
            3'd2:    return 4'h0;
            3'd3:    return (d == 4'h9) ? (~d ^ 4'h1) : ~d;
            3'd4:    return ~d | 4'b0001;
            default: return ~d;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned GM = (g == 1) ? 1 : 0;
        localparam int unsigned GE = (g == 2) ? 2 : 8;
        not_gate_bist_if #(.WIDTH(4), .ERR_W(GE)) ifc ();
        logic [3:0] din;
        logic [3:0] dout;

        assign ifc.start = start_r[g];
        assign dout      = bank(din, fault[g]);

        not_gate_bist #(.WIDTH(4), .SETTLE(SETTLE), .MODE(GM), .ERR_W(GE)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .ctl     (ifc),
            .dut_out (dout),
            .dut_in  (din)
        );

        assign din_w[g]  = din;
        assign dout_w[g] = dout;
        assign busy_w[g] = ifc.busy;
        assign done_w[g] = ifc.done;
        assign pass_w[g] = ifc.pass;
        assign err_w[g]  = 8'(ifc.err_count);
`ifdef NOT_BIST_ERRLOG_EN
        assign fv_w[g]   = ifc.fail_valid;
        assign fvec_w[g] = ifc.fail_vec;
        assign fout_w[g] = ifc.fail_out;
`endif
    end

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h", name, i, act, expv);
        end
    endtask

    // Hand-written vector sequences: MODE 0 counts 0..F, MODE 1 is 1,2,4,8,E,D,B,7
    task automatic expect_run(input int i, input logic [7:0] err, input logic pass,
                              input logic fv, input logic [3:0] fvec, input logic [3:0] fout);
        exp_t e;
        if (i == 1) begin
            e.vec = 64'h0000_0000_7BDE_8421;
            e.nv  = 8'd8;
        end else begin
            e.vec = 64'hFEDC_BA98_7654_3210;
            e.nv  = 8'd16;
        end
        e.err  = err;
        e.pass = pass;
        e.fv   = fv;
        e.fvec = fvec;
        e.fout = fout;
        exp_q[i].push_back(e);
    endtask

    task automatic pulse(input int i);
        @(posedge clk); #1 start_r[i] = 1'b1;
        @(posedge clk); #1 start_r[i] = 1'b0;
    endtask

    // Stimulus
    initial begin
        reset_n = 1'b1;
        start_r = '0;
        end_req = 1'b0;
        for (int i = 0; i < 3; i++) fault[i] = 3'd0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Ideal exhaustive run
        expect_run(0, 8'd0, 1'b1, 1'b0, 4'h0, 4'h0);
        pulse(0);
        repeat (36) @(posedge clk);

        // bit2 stuck-at-0: vectors with dut_in[2]=0 fail (8); first is 0 -> out B
        fault[0] = 3'd1;
        expect_run(0, 8'd8, 1'b0, 1'b1, 4'h0, 4'hB);
        pulse(0);
        repeat (36) @(posedge clk);

        // Walking patterns, ideal
        expect_run(1, 8'd0, 1'b1, 1'b0, 4'h0, 4'h0);
        pulse(1);
        repeat (20) @(posedge clk);

        // Walking patterns, bit0 stuck-at-1: 1,D,B,7 fail; first is 1 -> out F
        fault[1] = 3'd4;
        expect_run(1, 8'd4, 1'b0, 1'b1, 4'h1, 4'hF);
        pulse(1);
        repeat (20) @(posedge clk);

        // Output tied 0 with 2-bit counter: 15 failures saturate at 3
        fault[2] = 3'd2;
        expect_run(2, 8'd3, 1'b0, 1'b1, 4'h0, 4'h0);
        pulse(2);
        repeat (36) @(posedge clk);

        // Single fault at 9 plus start pulses while busy (must be ignored)
        fault[0] = 3'd3;
        expect_run(0, 8'd1, 1'b0, 1'b1, 4'h9, 4'h7);
        pulse(0);
        for (int k = 0; k < 3; k++) begin
            repeat (5) @(posedge clk);
            #1 start_r[0] = 1'b1;
            @(posedge clk); #1 start_r[0] = 1'b0;
        end
        repeat (20) @(posedge clk);

        // start held through DONE restarts on the next edge
        fault[0] = 3'd0;
        expect_run(0, 8'd0, 1'b1, 1'b0, 4'h0, 4'h0);
        expect_run(0, 8'd0, 1'b1, 1'b0, 4'h0, 4'h0);
        @(posedge clk); #1 start_r[0] = 1'b1;
        repeat (34) @(posedge clk);
        #1 start_r[0] = 1'b0;
        repeat (36) @(posedge clk);

        // Reset during vector 5 aborts; then a fresh run from vector 0
        expect_run(0, 8'd0, 1'b1, 1'b0, 4'h0, 4'h0);
        pulse(0);
        repeat (10) @(posedge clk);
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        expect_run(0, 8'd0, 1'b1, 1'b0, 4'h0, 4'h0);
        pulse(0);
        repeat (36) @(posedge clk);

        end_req = 1'b1;
    end

    // Monitor / scoreboard
    logic        active [3];
    int unsigned n      [3];
    exp_t        mon_e;

    initial begin
        for (int i = 0; i < 3; i++) begin
            active[i] = 1'b0;
            n[i]      = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!reset_n) begin
                    chk("rst_state", i, {busy_w[i], done_w[i], pass_w[i], err_w[i], din_w[i]}, 32'h0);
`ifdef NOT_BIST_ERRLOG_EN
                    chk("rst_errlog", i, {fv_w[i], fvec_w[i], fout_w[i]}, 32'h0);
`endif
                    active[i] = 1'b0;
                    exp_q[i].delete();
                end else begin
                    if (!active[i] && busy_w[i]) begin
                        active[i] = 1'b1;
                        n[i]      = 0;
                        chk("run_expected", i, 32'(exp_q[i].size() != 0), 32'h1);
                    end
                    if (active[i]) begin
                        if (busy_w[i]) begin
                            if (exp_q[i].size() != 0 && (n[i] % SETTLE) == 0 && (n[i] / SETTLE) < 16) begin
                                mon_e = exp_q[i][0];
                                chk("dut_in_step", i, 32'(din_w[i]), 32'(mon_e.vec[n[i] / SETTLE]));
                            end
                            n[i]++;
                            if (n[i] > 100) begin
                                chk("run_timeout", i, n[i], 32'd100);
                                active[i] = 1'b0;
                                if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
                            end
                        end else begin
                            chk("done_at_end", i, 32'(done_w[i]), 32'h1);
                            if (exp_q[i].size() != 0) begin
                                mon_e = exp_q[i].pop_front();
                                chk("run_length", i, n[i], 32'(mon_e.nv) * SETTLE);
                                chk("err_count", i, 32'(err_w[i]), 32'(mon_e.err));
                                chk("pass", i, 32'(pass_w[i]), 32'(mon_e.pass));
                                chk("last_vec", i, 32'(din_w[i]), 32'(mon_e.vec[mon_e.nv - 8'd1]));
`ifdef NOT_BIST_ERRLOG_EN
                                chk("fail_valid", i, 32'(fv_w[i]), 32'(mon_e.fv));
                                chk("fail_vec", i, 32'(fvec_w[i]), 32'(mon_e.fvec));
                                chk("fail_out", i, 32'(fout_w[i]), 32'(mon_e.fout));
`endif
                            end
                            active[i] = 1'b0;
                        end
                    end
                end
            end
            if (end_req) begin
                for (int i = 0; i < 3; i++) begin
                    chk("drain", i, 32'(exp_q[i].size()), 32'h0);
                    chk("idle_at_end", i, {busy_w[i], active[i]}, 32'h0);
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

endmodule
